// File: rtl/reg_file_scoreboard.sv
// 16 x DATA_W architectural register file with two bypassed combinational read
// ports, one clocked write port, and a pending-write scoreboard driving Stall.
module reg_file_scoreboard #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        SrcReg1,
  input  logic [3:0]        SrcReg2,
  input  logic              Src1Used,
  input  logic              Src2Used,
  output logic [DATA_W-1:0] SrcData1,
  output logic [DATA_W-1:0] SrcData2,
  input  logic              WriteReg,
  input  logic [3:0]        DstReg,
  input  logic [DATA_W-1:0] DstData,
  input  logic              IssueEn,
  input  logic [3:0]        IssueReg,
  output logic [15:0]       Busy,
  output logic              Stall
);
  localparam int NREG = 16;

  logic [DATA_W-1:0] r_regs [1:NREG-1];
  logic [NREG-1:1]   r_busy;

  logic [NREG-1:0]   w_src1_wl;
  logic [NREG-1:0]   w_src2_wl;
  logic [NREG-1:0]   w_dst_wl;
  logic [NREG-1:0]   w_dst_wl_nz;
  logic [NREG-1:0]   w_issue_wl;
  logic [DATA_W-1:0] w_rd_val [NREG];
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic              w_bypass1;
  logic              w_bypass2;
  logic              w_pend1;
  logic              w_pend2;
  logic [NREG-1:1]   w_busy_next;

  // One-hot wordlines for both read ports, the write port and the issue port.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_dec
      assign w_src1_wl[gi]  = (SrcReg1 == 4'(gi));
      assign w_src2_wl[gi]  = (SrcReg2 == 4'(gi));
      assign w_dst_wl[gi]   = WriteReg & (DstReg == 4'(gi));
      assign w_issue_wl[gi] = IssueEn & ~Stall & (IssueReg == 4'(gi));
    end
  endgenerate

  // R0 is never stored, so the write wordline for it is masked off everywhere.
  assign w_dst_wl_nz = {w_dst_wl[NREG-1:1], 1'b0};

  assign w_rd_val[0] = '0;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_rd_val
      assign w_rd_val[gi] = r_regs[gi];
    end
  endgenerate

  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    for (int i = 0; i < NREG; i++) begin
      w_rd1 = w_rd1 | (w_rd_val[i] & {DATA_W{w_src1_wl[i]}});
      w_rd2 = w_rd2 | (w_rd_val[i] & {DATA_W{w_src2_wl[i]}});
    end
  end

  assign w_bypass1 = |(w_dst_wl_nz & w_src1_wl);
  assign w_bypass2 = |(w_dst_wl_nz & w_src2_wl);

  assign SrcData1 = w_bypass1 ? DstData : w_rd1;
  assign SrcData2 = w_bypass2 ? DstData : w_rd2;

  assign Busy = {r_busy, 1'b0};

  // Busy[0] is constant zero, so a source ID of 0 can never stall.
  assign w_pend1 = |(Busy & w_src1_wl);
  assign w_pend2 = |(Busy & w_src2_wl);
  assign Stall   = (Src1Used & w_pend1 & ~w_bypass1) |
                   (Src2Used & w_pend2 & ~w_bypass2);

  // A new producer issued in the same cycle as the old one retires keeps the bit set.
  always_comb begin
    w_busy_next = r_busy;
    for (int i = 1; i < NREG; i++) begin
      if (w_issue_wl[i]) begin
        w_busy_next[i] = 1'b1;
      end else if (w_dst_wl[i]) begin
        w_busy_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 1; i < NREG; i++) begin
      if (rst) begin
        r_regs[i] <= '0;
      end else if (w_dst_wl_nz[i]) begin
        r_regs[i] <= DstData;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard: bypass, R0 handling, scoreboard
// set/clear priority, stall gating and reset behaviour.
module tb_reg_file_scoreboard;
  logic        clk;
  logic        rst;
  logic [3:0]  SrcReg1;
  logic [3:0]  SrcReg2;
  logic        Src1Used;
  logic        Src2Used;
  logic [15:0] SrcData1;
  logic [15:0] SrcData2;
  logic        WriteReg;
  logic [3:0]  DstReg;
  logic [15:0] DstData;
  logic        IssueEn;
  logic [3:0]  IssueReg;
  logic [15:0] Busy;
  logic        Stall;

  int n_vec;
  int n_bad;

  reg_file_scoreboard #(.DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
    .Src1Used(Src1Used), .Src2Used(Src2Used),
    .SrcData1(SrcData1), .SrcData2(SrcData2),
    .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
    .IssueEn(IssueEn), .IssueReg(IssueReg),
    .Busy(Busy), .Stall(Stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%04h", tag, got);
    end
  endtask

  // Advance one clock edge; inputs change 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WriteReg = 1'b0;
    IssueEn  = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    SrcReg1 = 4'd0; SrcReg2 = 4'd0; Src1Used = 1'b0; Src2Used = 1'b0;
    WriteReg = 1'b0; DstReg = 4'd0; DstData = 16'h0000;
    IssueEn = 1'b0; IssueReg = 4'd0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state across all IDs
    for (int i = 0; i < 16; i++) begin
      SrcReg1 = 4'(i);
      SrcReg2 = 4'(15 - i);
      #1;
      chk($sformatf("rst_rd1_r%0d", i), SrcData1, 16'h0000);
      chk($sformatf("rst_rd2_r%0d", 15 - i), SrcData2, 16'h0000);
    end
    chk("rst_busy", Busy, 16'h0000);
    chk("rst_stall", {15'b0, Stall}, 16'h0000);

    // Write R5 with bypass then storage
    WriteReg = 1'b1; DstReg = 4'd5; DstData = 16'hBEEF; SrcReg1 = 4'd5;
    #1;
    chk("r5_bypass", SrcData1, 16'hBEEF);
    tick();
    idle();
    #1;
    chk("r5_stored", SrcData1, 16'hBEEF);

    // R0 writes discarded
    WriteReg = 1'b1; DstReg = 4'd0; DstData = 16'h1234; SrcReg1 = 4'd0; SrcReg2 = 4'd0;
    #1;
    chk("r0_no_bypass", SrcData1, 16'h0000);
    tick();
    idle();
    #1;
    chk("r0_after_wr1", SrcData1, 16'h0000);
    chk("r0_after_wr2", SrcData2, 16'h0000);
    chk("r0_busy", Busy, 16'h0000);

    // Issue R3, then read it as a used / unused operand
    IssueEn = 1'b1; IssueReg = 4'd3;
    tick();
    idle();
    SrcReg2 = 4'd3; Src2Used = 1'b1;
    #1;
    chk("busy3_set", Busy, 16'h0008);
    chk("stall_src2_used", {15'b0, Stall}, 16'h0001);
    Src2Used = 1'b0;
    #1;
    chk("stall_src2_unused", {15'b0, Stall}, 16'h0000);

    // Writeback R3 satisfies the pending operand in the same cycle
    SrcReg1 = 4'd3; Src1Used = 1'b1;
    #1;
    chk("stall_src1_pending", {15'b0, Stall}, 16'h0001);
    WriteReg = 1'b1; DstReg = 4'd3; DstData = 16'h00A5;
    #1;
    chk("wb3_stall_drop", {15'b0, Stall}, 16'h0000);
    chk("wb3_bypass", SrcData1, 16'h00A5);
    tick();
    idle();
    #1;
    chk("busy3_clear", Busy, 16'h0000);
    chk("r3_stored", SrcData1, 16'h00A5);
    Src1Used = 1'b0;

    // Set wins over clear on R7
    IssueEn = 1'b1; IssueReg = 4'd7;
    tick();
    idle();
    #1;
    chk("busy7_set", Busy, 16'h0080);
    WriteReg = 1'b1; DstReg = 4'd7; DstData = 16'h7777;
    IssueEn = 1'b1; IssueReg = 4'd7;
    tick();
    idle();
    SrcReg2 = 4'd7;
    #1;
    chk("busy7_set_wins", Busy, 16'h0080);
    chk("r7_stored", SrcData2, 16'h7777);

    // Issue during stall is dropped
    SrcReg1 = 4'd7; Src1Used = 1'b1;
    IssueEn = 1'b1; IssueReg = 4'd9;
    #1;
    chk("stall_on_r7", {15'b0, Stall}, 16'h0001);
    tick();
    idle();
    Src1Used = 1'b0;
    #1;
    chk("busy9_ignored", Busy, 16'h0080);

    // Fill R1..R15 and all busy bits, then reset
    for (int i = 1; i < 16; i++) begin
      WriteReg = 1'b1; DstReg = 4'(i); DstData = 16'(i * 16'h1111);
      IssueEn = 1'b1; IssueReg = 4'(i);
      tick();
    end
    idle();
    SrcReg1 = 4'd1; SrcReg2 = 4'd15;
    #1;
    chk("fill_busy", Busy, 16'hFFFE);
    chk("fill_r1", SrcData1, 16'h1111);
    chk("fill_r15", SrcData2, 16'hFFFF);

    // Reset wins over a concurrent write and issue
    rst = 1'b1;
    WriteReg = 1'b1; DstReg = 4'd4; DstData = 16'hAAAA;
    IssueEn = 1'b1; IssueReg = 4'd4;
    tick();
    rst = 1'b0;
    idle();
    SrcReg1 = 4'd5; SrcReg2 = 4'd5; Src1Used = 1'b1; Src2Used = 1'b1;
    #1;
    chk("post_rst_busy", Busy, 16'h0000);
    chk("post_rst_stall", {15'b0, Stall}, 16'h0000);
    Src1Used = 1'b0; Src2Used = 1'b0;
    for (int i = 0; i < 16; i++) begin
      SrcReg1 = 4'(i);
      SrcReg2 = 4'(i);
      #1;
      chk($sformatf("post_rst_rd1_r%0d", i), SrcData1, 16'h0000);
      chk($sformatf("post_rst_rd2_r%0d", i), SrcData2, 16'h0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
